// File: rtl/seq_alu.sv
// seq_alu: registered add/sub/mul/AND unit with a valid/ready handshake on the input side
// and a one-cycle completion pulse on the output side.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   A, B       WIDTH-bit unsigned operands, sampled only on acceptance
//   sel        00 add, 01 sub, 10 mul (or A|B without SEQ_ALU_MUL_EN), 11 AND
//   in_valid   operands/sel valid this cycle
//   in_ready   block can accept an operation this cycle (state only, no path from in_valid)
//   y          2*WIDTH-bit result, held until the next completion
//   out_valid  one-cycle pulse: y was updated on this edge
//   zero       registered y == 0, updated together with y
//
// Configuration macro: SEQ_ALU_MUL_EN
//   defined   : sel=10 runs an iterative shift-add multiply over WIDTH cycles
//   undefined : sel=10 is a single-cycle zero-extended A|B, no busy state
module seq_alu #(
    parameter int unsigned WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               out_valid,
    output logic               zero
);

    localparam int unsigned YW = 2 * WIDTH;

    logic [YW-1:0] a_ext;
    logic [YW-1:0] b_ext;
    logic [YW-1:0] simple_res;

    logic [YW-1:0] y_q, y_d;
    logic          zero_q, zero_d;
    logic          out_valid_q, out_valid_d;

    assign a_ext = {{WIDTH{1'b0}}, A};
    assign b_ext = {{WIDTH{1'b0}}, B};

    // Single-cycle results; sub wraps modulo 2^YW so A<B sets all upper bits.
    always_comb begin
        simple_res = '0;
        case (sel)
            2'b00: simple_res = a_ext + b_ext;
            2'b01: simple_res = a_ext - b_ext;
`ifdef SEQ_ALU_MUL_EN
            2'b10: simple_res = '0;  // multiply goes through the iterative path
`else
            2'b10: simple_res = a_ext | b_ext;
`endif
            2'b11: simple_res = a_ext & b_ext;
            default: simple_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN

    typedef enum logic {StIdle, StMul} state_e;

    localparam int unsigned          CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [YW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [YW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [YW-1:0]    prod_step;

    assign in_ready  = (state_q == StIdle);
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (sel == 2'b10) begin
                        mcand_d  = a_ext;
                        mplier_d = B;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        y_d         = simple_res;
                        zero_d      = (simple_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    y_d         = prod_step;
                    zero_d      = (prod_step == '0);
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

`else

    logic accept;

    // No busy state: ready everywhere except while reset is held.
    assign in_ready = ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        y_d         = y_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (accept) begin
            y_d         = simple_res;
            zero_d      = (simple_res == '0);
            out_valid_d = 1'b1;
        end
    end

`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the team's combinational 2-bit four-function ALU. Accepts two WIDTH-bit operands and a 2-bit operation select through a valid/ready handshake. Returns a registered 2*WIDTH-bit result with a one-cycle completion pulse. Add, subtract and AND complete in one cycle; multiply runs as an iterative shift-add over WIDTH cycles. Sits between operand registers and the result display/bus logic in the lab datapath.

## Interface
- WIDTH, 2, operand width in bits; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- sel  in  2  operation: 00 add, 01 sub, 10 mul, 11 AND.
- in_valid  in  1  operands and sel are valid this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- y  out  2*WIDTH  result, held until the next completion.
- out_valid  out  1  one-cycle pulse: y was updated on this edge.
- zero  out  1  registered; high when y == 0; updated with y.

## Operation
- Acceptance: rising edge with in_valid && in_ready. A, B and sel are sampled only at acceptance.
- States:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0; in_valid is ignored, nothing is queued.
- Accept add, sub or AND: y, zero and out_valid are written on the acceptance edge. State stays IDLE, so back-to-back acceptance every cycle is legal.
- Accept mul: load multiplicand, multiplier and a zeroed partial product; clear the counter; go to MUL.
- In MUL, each edge does one shift-add step and increments the counter. On the WIDTH-th step:
  - y = product, out_valid = 1, update zero.
  - Go to IDLE.
- Arithmetic, all in 2*WIDTH bits:
  - add: zero-extended A+B; carry lands in bit WIDTH.
  - sub: zero-extended A minus zero-extended B, modulo 2^(2*WIDTH). A<B gives two's-complement negative with all upper bits set.
  - mul: exact unsigned product.
  - AND: upper WIDTH bits zero.
- out_valid is deasserted on every edge that does not complete an operation.
- y and zero hold between completions.
- Reset, including mid-multiply:
  - State IDLE, y = 0, zero = 1, out_valid = 0, in_ready = 1, counter = 0.
  - The in-flight multiply is discarded with no completion pulse.

## Timing
- Add/sub/AND latency: 1. Accepted at edge k, y and out_valid visible after edge k.
- Mul latency: WIDTH edges after acceptance.
  - Accepted at edge k: in_ready low after k; y and out_valid visible after edge k+WIDTH.
  - in_ready is high again in that same cycle, so a new op can be accepted at edge k+WIDTH+1.
- Throughput: 1 op/cycle for add/sub/AND; one mul per WIDTH+1 cycles.
- in_ready depends on state only, with no combinational path from in_valid.
- Operand changes while busy have no effect on the in-flight result.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - sel=10 is the iterative multiplier above; MUL state and counter are present.
- SEQ_ALU_MUL_EN undefined:
  - sel=10 computes zero-extended A|B with 1-cycle latency.
  - No MUL state; in_ready is tied to 1 (driven low only during reset).
  - All other behaviour is unchanged.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> immediately y=0, zero=1, out_valid=0, in_ready=1.
- WIDTH=2, back-to-back on consecutive edges: add A=3,B=3; sub A=1,B=2; AND A=3,B=1; add A=0,B=0.
  - Results on consecutive cycles: y=0110, 1111, 0001, 0000.
  - out_valid high for 4 cycles; zero high only on the last.
- WIDTH=2, mul A=3,B=3 with MUL_EN:
  - in_ready low for 2 cycles; y=1001 with a single out_valid pulse 2 edges after acceptance.
  - A mul/AND presented with in_valid during the busy cycles is not accepted and does not change the result.
- WIDTH=4, mul A=15,B=15 -> y=0xE1 after 4 edges; then sub A=0,B=1 accepted next edge -> y=0xFF.
- WIDTH=2, mul A=2,B=3 with rst pulsed after 1 step -> no out_valid; y=0; in_ready=1; a following add A=1,B=1 returns y=0010.
- MUL_EN undefined, WIDTH=2: sel=10, A=2, B=1 -> y=0011 after 1 edge; in_ready constantly 1.
